// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for a shared bus with bounded lock support.
// Grant, bus data, valid and owner are registered and update together.
module shared_bus_arbiter #(
  parameter int DATA_W   = 16,
  parameter int NSRC     = 17,
  parameter int SEL_W    = 5,
  parameter int NCORE    = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [NCORE-1:0]       core_req,
  input  logic [NCORE*SEL_W-1:0] core_sel,
  input  logic [NCORE-1:0]       core_lock,
  output logic [NCORE-1:0]       grant,
  output logic [DATA_W-1:0]      bus_out,
  output logic                   bus_valid,
  output logic [2:0]             bus_owner
);

  localparam int IDX_W = $clog2(NCORE);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    LOCK = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NCORE-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  bus_q, bus_d;
  logic               valid_q, valid_d;
  logic [2:0]         owner_q, owner_d;

  logic [NCORE-1:0]   cand;
  logic               hold;
  logic               f_hi, f_all;
  logic [IDX_W-1:0]   w_hi, w_all;
  logic [IDX_W-1:0]   win;
  logic               win_vld;
  logic [SEL_W-1:0]   sel;
  int                 start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NCORE - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    cand    = core_req;
    hold    = 1'b0;
    state_d = IDLE;
    cnt_d   = '0;
    last_d  = last_q;
    start   = (int'(last_q) + 1) % NCORE;
    unique case (state_q)
      LOCK: begin
        if (core_req[last_q] && core_lock[last_q]) begin
          if (cnt_q < CNT_W'(LOCK_MAX)) hold = 1'b1;
          else cand[last_q] = 1'b0;
        end
      end
      default: ;
    endcase
    // Lowest requester at/after the pointer, else wrap to the lowest overall.
    f_hi  = 1'b0;
    f_all = 1'b0;
    w_hi  = '0;
    w_all = '0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      if (cand[i]) begin
        f_all = 1'b1;
        w_all = IDX_W'(i);
        if (i >= start) begin
          f_hi = 1'b1;
          w_hi = IDX_W'(i);
        end
      end
    end
    win     = f_hi ? w_hi : w_all;
    win_vld = f_all;
    if (hold) begin
      win     = last_q;
      win_vld = 1'b1;
      state_d = LOCK;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (win_vld) begin
      last_d = win;
      if (core_lock[win]) begin
        state_d = LOCK;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = OWN;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    bus_d   = '0;
    valid_d = 1'b0;
    owner_d = '0;
    sel     = '0;
    if (win_vld) begin
      grant_d[win] = 1'b1;
      valid_d      = 1'b1;
      owner_d      = 3'(win);
      sel          = core_sel[int'(win)*SEL_W +: SEL_W];
      for (int k = 1; k <= NSRC; k++) begin
        if (sel == SEL_W'(k)) bus_d = src_data[k*DATA_W-1 -: DATA_W];
      end
    end
  end

  assign grant     = grant_q;
  assign bus_out   = bus_q;
  assign bus_valid = valid_q;
  assign bus_owner = owner_q;

endmodule

// File: doc/shared_bus_arbiter.md
SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: width of every source word and of bus_out.
REQ-002 Parameter NSRC, default 17: number of bus sources; valid select codes are 1..NSRC.
REQ-003 Parameter SEL_W, default 5: select-code width; the design SHALL support any NSRC <= 2**SEL_W-1.
REQ-004 Parameter NCORE, default 4: number of requesting cores (2..8).
REQ-005 Parameter LOCK_MAX, default 8: maximum consecutive cycles one core may hold a locked grant.
REQ-006 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port rst_n, input, 1: reset; it is asynchronous and active-low.
REQ-008 Port src_data, input, NSRC*DATA_W: packed sources; code k selects slice [k*DATA_W-1 -: DATA_W].
REQ-009 Port core_req, input, NCORE: per-core bus request.
REQ-010 Port core_sel, input, NCORE*SEL_W: per-core select code; core i uses slice [i*SEL_W +: SEL_W].
REQ-011 Port core_lock, input, NCORE: per-core request to keep the grant next cycle.
REQ-012 Port grant, output, NCORE: registered one-hot grant; all-zero means bus idle.
REQ-013 Port bus_out, output, DATA_W: registered bus data.
REQ-014 Port bus_valid, output, 1: registered; high when bus_out carries a granted transfer.
REQ-015 Port bus_owner, output, 3: registered index of the granted core; 0 when idle.

Function
REQ-016 FSM states SHALL be IDLE, OWN and LOCK, with one registered arbitration per cycle.
REQ-017 IDLE: if any core_req is high, the FSM SHALL grant using round-robin and go to OWN or LOCK; otherwise it SHALL stay in IDLE with grant=0.
REQ-018 Round-robin search order SHALL start at (last granted index + 1) mod NCORE; after reset the last granted index is NCORE-1, so core 0 has first priority.
REQ-019 Grant target is LOCK if the winner's core_lock is high in the arbitration cycle, else OWN.
REQ-020 OWN: each cycle SHALL re-arbitrate exactly as in IDLE, with the pointer advanced past the current owner.
REQ-021 LOCK: the owner SHALL retain the grant while its core_req and core_lock are both high and the lock counter is below LOCK_MAX.
REQ-022 LOCK: the lock counter SHALL load 1 on lock entry and increment on each retained cycle.
REQ-023 LOCK: when the owner drops core_req or core_lock, the FSM SHALL re-arbitrate that cycle, excluding no core.
REQ-024 LOCK: when the lock counter reaches LOCK_MAX, the FSM SHALL re-arbitrate with the current owner masked for that one cycle, which guarantees at most LOCK_MAX consecutive grants.
REQ-025 LOCK_MAX forced release with no other requester: the FSM SHALL go to IDLE for one cycle (grant=0, bus_valid=0).
REQ-026 On each edge where a grant is issued, bus_out SHALL load the source selected by the winner's core_sel, sampled that same cycle.
REQ-027 Latency SHALL be one cycle from request to grant, bus_out and bus_valid, which all update together.
REQ-028 Select code 0, or any code > NSRC, SHALL give bus_out=0 while bus_valid is still 1.
REQ-029 With no grant, bus_out SHALL be 0 and bus_valid SHALL be 0.
REQ-030 grant SHALL never have more than one bit set.
REQ-031 bus_owner SHALL equal the index of the set grant bit.
REQ-032 Simultaneous requests SHALL be resolved only by the round-robin pointer; there are no fixed priorities.
REQ-033 core_sel and core_lock of non-granted cores SHALL be ignored.

Reset
REQ-034 While rst_n=0, the design SHALL hold: state=IDLE, grant=0, bus_out=0, bus_valid=0, bus_owner=0, lock counter=0, last-granted index=NCORE-1.
REQ-035 Reset asserted mid-transfer or mid-lock SHALL clear the outputs immediately (asynchronously).
REQ-036 After reset release, the first arbitration SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-037 Scenario: core_req=0001, core_sel0=1, src pc=16'h1234 -> next cycle grant=0001, bus_out=16'h1234, bus_valid=1, bus_owner=0.
REQ-038 Scenario: core_req=1111 held, no locks, 8 cycles -> grants 0001,0010,0100,1000,0001,... with no repeats within 4 cycles.
REQ-039 Scenario: core1 locks with core_req=0011 held, LOCK_MAX=8 -> core1 granted 8 consecutive cycles, then core0 granted for 1 cycle.
REQ-040 Scenario: sole requester core2 with lock held -> 8 grants, 1 idle cycle (bus_valid=0), then re-grant to core2.
REQ-041 Scenario: granted core_sel=0 or 18 -> bus_out=0, bus_valid=1.
REQ-042 Scenario: rst_n dropped mid-lock, between clock edges -> grant=0, bus_out=0, bus_valid=0 immediately; after release, core_req=1111 -> core0 granted first.
